// File: rtl/load_read_unit16_pkg.sv
// Shared definitions for the load read unit: FSM state encoding and default sizes.
package load_read_unit16_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        WB   = 2'd3
    } lru_state_e;

    localparam int DW_DEF      = 16;
    localparam int AW_DEF      = 16;
    localparam int RW_DEF      = 4;
    localparam int TIMEOUT_DEF = 15;
    localparam int CTR_W       = 4;

    // True while a load is in flight and the pipeline must hold.
    function automatic logic is_busy(input lru_state_e s);
        return s != IDLE;
    endfunction

endpackage

// File: rtl/D_flip_flop.sv
// Single-bit enabled register with async active-low clear.
module D_flip_flop (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic d,
    output logic q
);

    // Load d when enabled, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  q <= 1'b0;
        else if (en) q <= d;
    end

endmodule

// File: rtl/flipFlop16.sv
// Word-wide enabled register with async active-low clear (16 bits by default).
module flipFlop16 #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Load d when enabled, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  q <= '0;
        else if (en) q <= d;
    end

endmodule

// File: rtl/load_timeout_ctr.sv
// Timeout counter for the WAIT state: clear-dominant, counts while enabled, saturates
// at LIMIT. term flags the cycle whose increment would reach LIMIT, so the caller can
// abort after exactly LIMIT waiting cycles.
module load_timeout_ctr #(
    parameter int           W     = 4,
    parameter logic [W-1:0] LIMIT = 4'd15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic term
);

    logic [W-1:0] cnt;

    // Count waiting cycles; never wraps past LIMIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   cnt <= '0;
        else if (clr)                 cnt <= '0;
        else if (en && cnt != LIMIT)  cnt <= cnt + 1'b1;
    end

    assign term = (cnt == LIMIT - 1'b1);

endmodule

// File: rtl/load_read_unit16.sv
// Load read unit: accepts a load, runs a req/ack read on data memory, and returns the
// word to the register file as a one-cycle writeback strobe. Aborts with a sticky err
// if memory does not answer within TIMEOUT waiting cycles.
module load_read_unit16
    import load_read_unit16_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int AW      = AW_DEF,
    parameter int RW      = RW_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ld_valid,
    input  logic [AW-1:0] ld_addr,
    input  logic [RW-1:0] ld_rd,
    output logic          ld_ready,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic          wb_valid,
    output logic [RW-1:0] wb_rd,
    output logic [DW-1:0] wb_data,
    output logic          stall,
    output logic          err
);

    lru_state_e    state;
    logic [RW-1:0] rd_q;
    logic          accept;
    logic          in_read;
    logic          ack_take;
    logic          term;

    assign ld_ready = (state == IDLE);
    assign stall    = is_busy(state);
    assign accept   = ld_valid && ld_ready;
    assign in_read  = (state == REQ) || (state == WAIT);
    // Acks outside REQ/WAIT are ignored so a stray ack cannot clobber the held word.
    assign ack_take = in_read && mem_ack;

    flipFlop16 #(.W(AW)) u_addr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (accept),
        .d     (ld_addr),
        .q     (mem_addr)
    );

    // The captured word drives wb_data directly; it only changes on a taken ack,
    // so it holds between strobes.
    flipFlop16 #(.W(DW)) u_data (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (ack_take),
        .d     (mem_rdata),
        .q     (wb_data)
    );

    for (genvar i = 0; i < RW; i++) begin : g_rd
        D_flip_flop u_rd_bit (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (accept),
            .d     (ld_rd[i]),
            .q     (rd_q[i])
        );
    end

    // Counter is held clear outside WAIT, so the first WAIT cycle starts from zero.
    load_timeout_ctr #(.W(CTR_W), .LIMIT(CTR_W'(TIMEOUT))) u_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state != WAIT),
        .en    (state == WAIT),
        .term  (term)
    );

    // Load FSM with registered request, strobe, writeback index and error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            wb_valid <= 1'b0;
            wb_rd    <= '0;
            err      <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        mem_req <= 1'b1;
                        err     <= 1'b0;
                        state   <= REQ;
                    end
                end
                REQ, WAIT: begin
                    // Ack beats timeout when both land in the same cycle.
                    if (mem_ack) begin
                        mem_req  <= 1'b0;
                        wb_valid <= 1'b1;
                        wb_rd    <= rd_q;
                        state    <= WB;
                    end else if (state == WAIT && term) begin
                        mem_req <= 1'b0;
                        err     <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        state <= WAIT;
                    end
                end
                WB:      state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
